// File: rtl/major_cycle_sequencer.sv
// major_cycle_sequencer
// Sequences the PDP-8 major cycles for one instruction at a time. It runs fetch,
// then a one-cycle decode, then any auto-index, indirect and execute phases.
// Each phase holds its ck* output high for CK_CYCLES clocks and then pulses its
// stb* output for one clock. Run, step and halt behaviour come from the run/step inputs.
//
// state  | meaning
// IDLE   | halted, waiting for run or a step pulse
// FETCH  | instruction fetch phase
// DECODE | one quiet cycle; decoded-IR flags sampled, path chosen
// AUTO1  | auto-index location read
// AUTO2  | auto-index location write-back
// IND    | indirect pointer read
// EXEC1  | execute phase 1
// EXEC2  | execute phase 2
// EXEC3  | execute phase 3
module major_cycle_sequencer #(
  parameter int CK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic       instIsIND,
  input  logic       instIsPPIND,
  input  logic [1:0] execCycles,
  output logic       ckFetch,
  output logic       stbFetch,
  output logic       ckAuto1,
  output logic       stbAuto1,
  output logic       ckAuto2,
  output logic       stbAuto2,
  output logic       ckInd,
  output logic       stbInd,
  output logic       ckExec1,
  output logic       stbExec1,
  output logic       ckExec2,
  output logic       stbExec2,
  output logic       ckExec3,
  output logic       stbExec3,
  output logic       running,
  output logic       instDone
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, AUTO1, AUTO2, IND, EXEC1, EXEC2, EXEC3
  } state_t;

  localparam logic [2:0] CK_LOAD = 3'(CK_CYCLES);

  state_t     state, stateNext;
  logic [2:0] phaseCnt;
  logic [1:0] execReg;
  logic       endInst;
  logic       phaseDone;

  // The phase counter reloads on every state change and counts down while ck is
  // high. Zero marks the strobe cycle. Only execCycles matters after DECODE,
  // because the indirect path is chosen during DECODE itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phaseCnt <= 3'd0;
      execReg  <= 2'd0;
    end else begin
      state <= stateNext;
      if (stateNext != state)
        phaseCnt <= CK_LOAD;
      else if (phaseCnt != 3'd0)
        phaseCnt <= phaseCnt - 3'd1;
      if (state == DECODE)
        execReg <= execCycles;
    end
  end

  // Next-state logic. The end of an instruction goes to FETCH if run is high and to IDLE otherwise.
  always_comb begin
    stateNext = state;
    endInst   = 1'b0;
    phaseDone = (phaseCnt == 3'd0);
    case (state)
      IDLE:   if (run || step) stateNext = FETCH;
      FETCH:  if (phaseDone) stateNext = DECODE;
      DECODE: begin
        if (instIsPPIND)               stateNext = AUTO1;
        else if (instIsIND)            stateNext = IND;
        else if (execCycles != 2'd0)   stateNext = EXEC1;
        else                           endInst   = 1'b1;
      end
      AUTO1:  if (phaseDone) stateNext = AUTO2;
      AUTO2:  if (phaseDone) stateNext = IND;
      IND: begin
        if (phaseDone) begin
          if (execReg != 2'd0) stateNext = EXEC1;
          else                 endInst   = 1'b1;
        end
      end
      EXEC1: begin
        if (phaseDone) begin
          if (execReg >= 2'd2) stateNext = EXEC2;
          else                 endInst   = 1'b1;
        end
      end
      EXEC2: begin
        if (phaseDone) begin
          if (execReg == 2'd3) stateNext = EXEC3;
          else                 endInst   = 1'b1;
        end
      end
      EXEC3:  if (phaseDone) endInst = 1'b1;
      default: stateNext = IDLE;
    endcase
    if (endInst)
      stateNext = run ? FETCH : IDLE;
  end

  // Phase outputs. Everything is forced low while reset is held, so an aborted phase never strobes.
  always_comb begin
    ckFetch  = 1'b0; stbFetch = 1'b0;
    ckAuto1  = 1'b0; stbAuto1 = 1'b0;
    ckAuto2  = 1'b0; stbAuto2 = 1'b0;
    ckInd    = 1'b0; stbInd   = 1'b0;
    ckExec1  = 1'b0; stbExec1 = 1'b0;
    ckExec2  = 1'b0; stbExec2 = 1'b0;
    ckExec3  = 1'b0; stbExec3 = 1'b0;
    running  = 1'b0;
    instDone = 1'b0;
    if (!reset) begin
      running  = (state != IDLE);
      instDone = endInst;
      case (state)
        FETCH: begin ckFetch = !phaseDone; stbFetch = phaseDone; end
        AUTO1: begin ckAuto1 = !phaseDone; stbAuto1 = phaseDone; end
        AUTO2: begin ckAuto2 = !phaseDone; stbAuto2 = phaseDone; end
        IND:   begin ckInd   = !phaseDone; stbInd   = phaseDone; end
        EXEC1: begin ckExec1 = !phaseDone; stbExec1 = phaseDone; end
        EXEC2: begin ckExec2 = !phaseDone; stbExec2 = phaseDone; end
        EXEC3: begin ckExec3 = !phaseDone; stbExec3 = phaseDone; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_major_cycle_sequencer.sv
// Directed bench for major_cycle_sequencer with CK_CYCLES=2.
// Each cycle the outputs are packed into one 16-bit word:
// bits 0-6 hold ck fetch/auto1/auto2/ind/exec1/exec2/exec3,
// bits 7-13 hold the matching stb signals, bit 14 is instDone and bit 15 is running.
module tb_major_cycle_sequencer;

  localparam int CK = 2;
  localparam int P_FETCH = 0, P_AUTO1 = 1, P_AUTO2 = 2, P_IND = 3;
  localparam int P_E1 = 4, P_E2 = 5, P_E3 = 6;
  localparam logic [15:0] RUN_B  = 16'h8000;
  localparam logic [15:0] DONE_B = 16'h4000;

  logic clk = 1'b0;
  logic reset, run, step, instIsIND, instIsPPIND;
  logic [1:0] execCycles;
  logic ckFetch, stbFetch, ckAuto1, stbAuto1, ckAuto2, stbAuto2, ckInd, stbInd;
  logic ckExec1, stbExec1, ckExec2, stbExec2, ckExec3, stbExec3, running, instDone;

  int nChecks = 0;
  int nFails  = 0;
  logic [15:0] expQ[$];

  always #5 clk = ~clk;

  major_cycle_sequencer #(.CK_CYCLES(CK)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .instIsIND(instIsIND), .instIsPPIND(instIsPPIND), .execCycles(execCycles),
    .ckFetch(ckFetch), .stbFetch(stbFetch), .ckAuto1(ckAuto1), .stbAuto1(stbAuto1),
    .ckAuto2(ckAuto2), .stbAuto2(stbAuto2), .ckInd(ckInd), .stbInd(stbInd),
    .ckExec1(ckExec1), .stbExec1(stbExec1), .ckExec2(ckExec2), .stbExec2(stbExec2),
    .ckExec3(ckExec3), .stbExec3(stbExec3), .running(running), .instDone(instDone)
  );

  function automatic logic [15:0] obs();
    return {running, instDone,
            stbExec3, stbExec2, stbExec1, stbInd, stbAuto2, stbAuto1, stbFetch,
            ckExec3, ckExec2, ckExec1, ckInd, ckAuto2, ckAuto1, ckFetch};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addPhase(input int p, input bit last);
    for (int i = 0; i < CK; i++) expQ.push_back(RUN_B | (16'd1 << p));
    expQ.push_back(RUN_B | (16'd1 << (7 + p)) | (last ? DONE_B : 16'd0));
  endtask

  task automatic addDecode(input bit last);
    expQ.push_back(RUN_B | (last ? DONE_B : 16'd0));
  endtask

  task automatic addIdle(input int n);
    for (int i = 0; i < n; i++) expQ.push_back(16'd0);
  endtask

  // Compare expQ cycle by cycle. Run drops after entry dropAt, and a one-cycle step pulse follows entry stepAt.
  task automatic checkSeq(input string name, input int dropAt, input int stepAt);
    logic [15:0] o;
    for (int k = 0; k < expQ.size(); k++) begin
      tick();
      step = 1'b0;
      o = obs();
      nChecks++;
      if (o !== expQ[k]) begin
        nFails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k + 1, o, expQ[k]);
      end
      if (k == dropAt) run = 1'b0;
      if (k == stepAt) step = 1'b1;
    end
    step = 1'b0;
    expQ.delete();
  endtask

  task automatic setFlags(input logic ind, input logic pp, input logic [1:0] ec);
    instIsIND = ind; instIsPPIND = pp; execCycles = ec;
  endtask

  task automatic test_reset();
    int guard;
    logic [15:0] o;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    setFlags(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (obs() !== 16'd0) begin
        nFails++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0000", i, obs());
      end
    end
    reset = 1'b0;
    setFlags(1'b0, 1'b1, 2'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    guard = 0;
    while (!ckAuto2 && guard < 40) begin
      tick();
      guard++;
    end
    nChecks++;
    if (!ckAuto2) begin
      nFails++;
      $display("FAIL reset_reach_auto2: got ckAuto2=%b expected 1", ckAuto2);
    end
    reset = 1'b1;
    #1;
    nChecks++;
    if (obs() !== 16'd0) begin
      nFails++;
      $display("FAIL reset_same_cycle: got %h expected 0000", obs());
    end
    tick();
    reset = 1'b0;
    nChecks++;
    if (obs() !== 16'd0) begin
      nFails++;
      $display("FAIL reset_after: got %h expected 0000", obs());
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      o = obs();
      nChecks++;
      if (o !== 16'd0) begin
        nFails++;
        $display("FAIL reset_no_resume cycle %0d: got %h expected 0000", i, o);
      end
    end
  endtask

  task automatic test_back_to_back();
    setFlags(1'b0, 1'b0, 2'd0);
    run = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b1);
    addPhase(P_FETCH, 1'b0); addDecode(1'b1);
    addIdle(2);
    checkSeq("back_to_back", 4, -1);
  endtask

  task automatic test_ppind();
    setFlags(1'b0, 1'b1, 2'd1);
    run = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b0);
    addPhase(P_AUTO1, 1'b0); addPhase(P_AUTO2, 1'b0); addPhase(P_IND, 1'b0);
    addPhase(P_E1, 1'b1);
    addIdle(2);
    checkSeq("ppind_exec1", 0, -1);
  endtask

  task automatic test_priority();
    setFlags(1'b1, 1'b1, 2'd0);
    run = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b0);
    addPhase(P_AUTO1, 1'b0); addPhase(P_AUTO2, 1'b0); addPhase(P_IND, 1'b1);
    addIdle(2);
    checkSeq("both_flags", 0, -1);
    setFlags(1'b1, 1'b0, 2'd2);
    run = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b0);
    addPhase(P_IND, 1'b0); addPhase(P_E1, 1'b0); addPhase(P_E2, 1'b1);
    addIdle(2);
    checkSeq("ind_only", 0, -1);
  endtask

  task automatic test_step();
    setFlags(1'b0, 1'b0, 2'd1);
    run = 1'b0;
    step = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b0); addPhase(P_E1, 1'b1);
    addIdle(4);
    checkSeq("step_single", -1, 2);
  endtask

  task automatic test_run_drop();
    setFlags(1'b0, 1'b0, 2'd3);
    run = 1'b1;
    addPhase(P_FETCH, 1'b0); addDecode(1'b0);
    addPhase(P_E1, 1'b0); addPhase(P_E2, 1'b0); addPhase(P_E3, 1'b1);
    addIdle(2);
    checkSeq("run_drop_exec2", 7, -1);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ppind();
    test_priority();
    test_step();
    test_run_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
